// File: rtl/hex_display_ctrl.sv
// Samples a debug value at a fixed refresh rate and shows it as hex on a bank of
// seven-segment digits, with hold, paging for wide values and leading-zero blanking.
module hex_display_ctrl #(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 5000000,
    parameter int ACTIVE_LOW  = 1,
    localparam int PAGES  = (DATA_W + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
    localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       value,
    input  logic                    hold,
    input  logic                    page_next,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [PAGE_W-1:0]       page,
    output logic                    sample_tick
);

    localparam int TOT_NIB = PAGES * NUM_DIGITS;
    localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);
    localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       snapshot;
    logic                    page_prev;
    logic                    slot;
    logic                    page_step;
    logic [4*TOT_NIB-1:0]    ext;
    logic [TOT_NIB-1:0]      nz_from;
    logic                    nz_acc;
    logic [3:0]              nib;
    logic                    nz;
    logic [6:0]              glyph;
    logic [7*NUM_DIGITS-1:0] seg_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign slot      = (cnt == CNT_MAX);
    assign page_step = page_next & ~page_prev;

    // Decode uses the registered snapshot and page, so a sample and a page step
    // landing on the same edge appear together in the next frame.
    always_comb begin
        ext = '0;
        ext[DATA_W-1:0] = snapshot;
        nz_from = '0;
        nz_acc = 1'b0;
        for (int g = TOT_NIB - 1; g >= 0; g--) begin
            nz_acc = nz_acc | (|ext[4*g +: 4]);
            nz_from[g] = nz_acc;
        end
        seg_next = '0;
        nib = 4'h0;
        nz = 1'b0;
        glyph = 7'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = 4'h0;
            nz = 1'b0;
            for (int p = 0; p < PAGES; p++) begin
                if (page == PAGE_W'(p)) begin
                    nib = ext[4*(p*NUM_DIGITS+i) +: 4];
                    nz  = nz_from[p*NUM_DIGITS+i];
                end
            end
            // Global nibble 0 always shows, so a zero value still reads "0".
            if (blank_lz && !nz && !((i == 0) && (page == '0)))
                glyph = 7'h00;
            else
                glyph = hex_glyph(nib);
            seg_next[7*i +: 7] = (ACTIVE_LOW != 0) ? ~glyph : glyph;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            snapshot    <= '0;
            page        <= '0;
            page_prev   <= 1'b0;
            sample_tick <= 1'b0;
            seg_out     <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            cnt         <= slot ? '0 : cnt + 1'b1;
            sample_tick <= slot;
            if (slot && !hold)
                snapshot <= value;
            page_prev <= page_next;
            if (page_step)
                page <= (page == PAGE_MAX) ? '0 : page + 1'b1;
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: a 32-bit/4-digit active-low instance with a
// 4-cycle refresh and a 20-bit/4-digit active-high instance refreshing every cycle.
module tb_hex_display_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        hold, page_next, blank_lz;
    logic [27:0] seg_out;
    logic [0:0]  page;
    logic        sample_tick;

    logic [19:0] b_value;
    logic        b_hold, b_page_next, b_blank_lz;
    logic [27:0] b_seg;
    logic [0:0]  b_page;
    logic        b_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int ticks;
    logic found;

    hex_display_ctrl #(.DATA_W(32), .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
        .clock(clock), .reset(reset), .value(value), .hold(hold),
        .page_next(page_next), .blank_lz(blank_lz), .seg_out(seg_out),
        .page(page), .sample_tick(sample_tick)
    );

    hex_display_ctrl #(.DATA_W(20), .NUM_DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW(0)) dut_b (
        .clock(clock), .reset(reset), .value(b_value), .hold(b_hold),
        .page_next(b_page_next), .blank_lz(b_blank_lz), .seg_out(b_seg),
        .page(b_page), .sample_tick(b_tick)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] d4(input logic [6:0] a3, input logic [6:0] a2,
                                       input logic [6:0] a1, input logic [6:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        reset = 1'b1; value = 32'h0000_0090; hold = 1'b0; page_next = 1'b0; blank_lz = 1'b0;
        b_value = 20'hABCDE; b_hold = 1'b0; b_page_next = 1'b0; b_blank_lz = 1'b0;

        // Reset state
        step(3);
        check("rst_seg", {4'h0, seg_out}, 32'h0FFF_FFFF);
        check("rst_page", {31'h0, page}, 32'h0);
        check("rst_tick", {31'h0, sample_tick}, 32'h0);
        check("rst_b_seg", {4'h0, b_seg}, 32'h0);
        check("rst_b_tick", {31'h0, b_tick}, 32'h0);

        // First sample of 0x90 and tick period of 4
        reset = 1'b0;
        step(3);
        check("tick_before_slot", {31'h0, sample_tick}, 32'h0);
        step(1);
        check("tick_first", {31'h0, sample_tick}, 32'h1);
        step(1);
        check("tick_one_cycle", {31'h0, sample_tick}, 32'h0);
        check("seg_0090", {4'h0, seg_out}, {4'h0, d4(7'h40, 7'h40, 7'h10, 7'h40)});
        step(3);
        check("tick_second", {31'h0, sample_tick}, 32'h1);

        // Paging through 0x12345678
        value = 32'h1234_5678;
        step(8);
        check("seg_5678", {4'h0, seg_out}, {4'h0, d4(7'h12, 7'h02, 7'h78, 7'h00)});
        page_next = 1'b1;
        step(1);
        check("page_to_1", {31'h0, page}, 32'h1);
        step(1);
        check("seg_1234", {4'h0, seg_out}, {4'h0, d4(7'h79, 7'h24, 7'h30, 7'h19)});
        page_next = 1'b0;
        step(1);
        page_next = 1'b1;
        step(1);
        check("page_wrap_0", {31'h0, page}, 32'h0);
        step(1);
        check("seg_5678_again", {4'h0, seg_out}, {4'h0, d4(7'h12, 7'h02, 7'h78, 7'h00)});
        page_next = 1'b0;

        // Hold freezes the snapshot while ticks continue
        value = 32'h0000_1111;
        step(8);
        check("seg_1111", {4'h0, seg_out}, {4'h0, d4(7'h79, 7'h79, 7'h79, 7'h79)});
        hold = 1'b1;
        value = 32'h0000_2222;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (sample_tick) ticks++;
        end
        check("hold_ticks", ticks, 32'd3);
        check("hold_seg", {4'h0, seg_out}, {4'h0, d4(7'h79, 7'h79, 7'h79, 7'h79)});
        hold = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            step(1);
            if (seg_out === d4(7'h24, 7'h24, 7'h24, 7'h24)) found = 1'b1;
        end
        check("release_2222", {31'h0, found}, 32'h1);

        // Leading-zero blanking
        blank_lz = 1'b1;
        value = 32'h0000_0090;
        step(8);
        check("lz_0090", {4'h0, seg_out}, {4'h0, d4(7'h7F, 7'h7F, 7'h10, 7'h40)});
        page_next = 1'b1;
        step(1);
        page_next = 1'b0;
        step(1);
        check("lz_page1_page", {31'h0, page}, 32'h1);
        check("lz_page1_blank", {4'h0, seg_out}, 32'h0FFF_FFFF);
        page_next = 1'b1;
        step(1);
        page_next = 1'b0;
        value = 32'h0;
        step(8);
        check("lz_zero", {4'h0, seg_out}, {4'h0, d4(7'h7F, 7'h7F, 7'h7F, 7'h40)});
        blank_lz = 1'b0;
        step(1);
        check("lz_off_zero", {4'h0, seg_out}, {4'h0, d4(7'h40, 7'h40, 7'h40, 7'h40)});

        // Held-high page_next steps only once
        page_next = 1'b1;
        step(20);
        check("held_high_page", {31'h0, page}, 32'h1);

        // Reset mid-operation
        reset = 1'b1;
        step(1);
        check("midrst_page", {31'h0, page}, 32'h0);
        check("midrst_seg", {4'h0, seg_out}, 32'h0FFF_FFFF);
        check("midrst_tick", {31'h0, sample_tick}, 32'h0);
        page_next = 1'b0;
        reset = 1'b0;
        step(3);
        check("restart_no_tick", {31'h0, sample_tick}, 32'h0);
        step(1);
        check("restart_tick", {31'h0, sample_tick}, 32'h1);

        // REFRESH_DIV=1, 20-bit value over two pages, active-high segments
        for (int k = 0; k < 4; k++) begin
            check("b_tick_const", {31'h0, b_tick}, 32'h1);
            step(1);
        end
        check("b_seg_bcde", {4'h0, b_seg}, {4'h0, d4(7'h7C, 7'h39, 7'h5E, 7'h79)});
        b_page_next = 1'b1;
        step(1);
        b_page_next = 1'b0;
        step(1);
        check("b_page1", {31'h0, b_page}, 32'h1);
        check("b_seg_000a", {4'h0, b_seg}, {4'h0, d4(7'h3F, 7'h3F, 7'h3F, 7'h77)});
        b_page_next = 1'b1;
        step(1);
        check("b_page_wrap", {31'h0, b_page}, 32'h0);
        b_page_next = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
